// File: rtl/cordic_sched.sv
// cordic_sched: round-robin time-multiplexer that lets nch channels share one CORDIC pipeline.
// Define CORDIC_SCHED_GAINCOMP_EN for gain-compensated x/y outputs (one extra output stage).
module cordic_sched #(
  parameter int width = 18,
  parameter int nch = 4,
  parameter int chw = 2,
  parameter int cordic_delay = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [chw-1:0]     wr_ch,
  input  logic [width-1:0]   wr_x,
  input  logic [width-1:0]   wr_y,
  input  logic [width:0]     wr_p,
  input  logic [1:0]         wr_op,
  output logic [1:0]         c_op,
  output logic [width-1:0]   c_x,
  output logic [width-1:0]   c_y,
  output logic [width:0]     c_p,
  input  logic [width-1:0]   c_xout,
  input  logic [width-1:0]   c_yout,
  input  logic [width:0]     c_pout,
  output logic               out_valid,
  output logic [chw-1:0]     out_ch,
  output logic [width-1:0]   out_x,
  output logic [width-1:0]   out_y,
  output logic [width:0]     out_p,
  output logic [nch-1:0]     overrun
);
  logic [width-1:0] sx [nch];
  logic [width-1:0] sy [nch];
  logic [width:0] sp [nch];
  logic [1:0] sop [nch];
  logic [nch-1:0] pending, pend_n;
  logic [chw-1:0] rr, sel, k, ich;
  logic found, wr_ok, iv;
  logic [cordic_delay-1:0] tv;
  logic [chw-1:0] tch [cordic_delay];
  assign wr_ok = wr_en && (int'(wr_ch) < nch);
  // Scan downward so the channel closest to rr is the last (winning) assignment
  always_comb begin
    found = 1'b0;
    sel = '0;
    k = '0;
    for (int i = nch - 1; i >= 0; i--) begin
      k = chw'((int'(rr) + i) % nch);
      if (pending[k]) begin
        found = 1'b1;
        sel = k;
      end
    end
  end
  always_comb begin
    pend_n = pending;
    if (found) pend_n[sel] = 1'b0;
    if (wr_ok) pend_n[wr_ch] = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      sx[wr_ch] <= wr_x;
      sy[wr_ch] <= wr_y;
      sp[wr_ch] <= wr_p;
      sop[wr_ch] <= wr_op;
    end
  end
  // iv/ich sit alongside c_*, so the tag pipe lines up with the CORDIC's own input stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
      rr <= '0;
      c_op <= '0;
      c_x <= '0;
      c_y <= '0;
      c_p <= '0;
      overrun <= '0;
      iv <= 1'b0;
      ich <= '0;
      tv <= '0;
      for (int i = 0; i < cordic_delay; i++) tch[i] <= '0;
    end else begin
      pending <= pend_n;
      iv <= found;
      ich <= sel;
      tv <= {tv[cordic_delay-2:0], iv};
      tch[0] <= ich;
      for (int i = 1; i < cordic_delay; i++) tch[i] <= tch[i-1];
      if (found) begin
        c_op <= sop[sel];
        c_x <= sx[sel];
        c_y <= sy[sel];
        c_p <= sp[sel];
        rr <= (sel == chw'(nch - 1)) ? '0 : sel + 1'b1;
      end
      if (wr_ok && pending[wr_ch] && !(found && sel == wr_ch)) overrun[wr_ch] <= 1'b1;
    end
  end
`ifdef CORDIC_SCHED_GAINCOMP_EN
  function automatic logic [width-1:0] gc(input logic [width-1:0] v);
    logic signed [width+1:0] e, s;
    e = signed'({{2{v[width-1]}}, v});
    s = (e >>> 1) + (e >>> 3) - (e >>> 6) - (e >>> 9);
    return s[width-1:0];
  endfunction
  logic s_v;
  logic [chw-1:0] s_ch;
  logic [width-1:0] s_x, s_y;
  logic [width:0] s_p;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_v <= 1'b0;
      s_ch <= '0;
      s_x <= '0;
      s_y <= '0;
      s_p <= '0;
      out_valid <= 1'b0;
      out_ch <= '0;
      out_x <= '0;
      out_y <= '0;
      out_p <= '0;
    end else begin
      s_v <= tv[cordic_delay-1];
      if (tv[cordic_delay-1]) begin
        s_ch <= tch[cordic_delay-1];
        s_x <= c_xout;
        s_y <= c_yout;
        s_p <= c_pout;
      end
      out_valid <= s_v;
      if (s_v) begin
        out_ch <= s_ch;
        out_x <= gc(s_x);
        out_y <= gc(s_y);
        out_p <= s_p;
      end
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_ch <= '0;
      out_x <= '0;
      out_y <= '0;
      out_p <= '0;
    end else begin
      out_valid <= tv[cordic_delay-1];
      if (tv[cordic_delay-1]) begin
        out_ch <= tch[cordic_delay-1];
        out_x <= c_xout;
        out_y <= c_yout;
        out_p <= c_pout;
      end
    end
  end
`endif
endmodule

// File: tb/tb_cordic_sched.sv
// tb_cordic_sched: randomized scoreboard bench for cordic_sched with a stand-in CORDIC pipeline.
module tb_cordic_sched;
  localparam int W = 18;
  localparam int PW = W + 1;
  localparam int N = 4;
  localparam int CW = 2;
  localparam int D = 20;
  logic clk = 1'b0, rst = 1'b0, wr_en = 1'b0;
  logic [CW-1:0] wr_ch = '0;
  logic [W-1:0] wr_x = '0, wr_y = '0;
  logic [PW-1:0] wr_p = '0;
  logic [1:0] wr_op = '0;
  logic [1:0] c_op;
  logic [W-1:0] c_x, c_y, c_xout, c_yout, out_x, out_y;
  logic [PW-1:0] c_p, c_pout, out_p;
  logic out_valid;
  logic [CW-1:0] out_ch;
  logic [N-1:0] overrun;
  always #5 clk = ~clk;
  cordic_sched #(.width(W), .nch(N), .chw(CW), .cordic_delay(D)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch), .wr_x(wr_x), .wr_y(wr_y),
    .wr_p(wr_p), .wr_op(wr_op), .c_op(c_op), .c_x(c_x), .c_y(c_y), .c_p(c_p),
    .c_xout(c_xout), .c_yout(c_yout), .c_pout(c_pout), .out_valid(out_valid),
    .out_ch(out_ch), .out_x(out_x), .out_y(out_y), .out_p(out_p), .overrun(overrun)
  );
  // Stand-in CORDIC: D register stages applying a simple, op-dependent transform
  logic [W-1:0] px [D];
  logic [W-1:0] py [D];
  logic [PW-1:0] pp [D];
  always @(posedge clk) begin
    px[0] <= c_x + W'(c_op);
    py[0] <= ~c_y;
    pp[0] <= c_p + 1'b1;
    for (int i = 1; i < D; i++) begin
      px[i] <= px[i-1];
      py[i] <= py[i-1];
      pp[i] <= pp[i-1];
    end
  end
  assign c_xout = px[D-1];
  assign c_yout = py[D-1];
  assign c_pout = pp[D-1];
  typedef struct {
    int due;
    logic [CW-1:0] ch;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [PW-1:0] p;
  } exp_t;
  exp_t sb[$];
  logic [W-1:0] mx [N];
  logic [W-1:0] my [N];
  logic [PW-1:0] mp [N];
  logic [1:0] mop [N];
  bit mpend [N];
  int mrr = 0;
  logic [N-1:0] movr = '0;
  int cyc = 0;
  int errors = 0, checks = 0, nvalid = 0;
  always @(posedge clk) cyc <= cyc + 1;
  // Transaction-level reference: issue the nearest pending channel from rr, then apply the write
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) mpend[i] = 1'b0;
      mrr = 0;
      movr = '0;
      sb.delete();
    end else begin
      int s;
      s = -1;
      for (int i = 0; i < N; i++) if (s < 0 && mpend[(mrr + i) % N]) s = (mrr + i) % N;
      if (s >= 0) begin
        sb.push_back('{cyc + D + 2, CW'(s), mx[s] + W'(mop[s]), ~my[s], mp[s] + 1'b1});
        mpend[s] = 1'b0;
        mrr = (s + 1) % N;
      end
      if (wr_en && int'(wr_ch) < N) begin
        if (mpend[wr_ch]) movr[wr_ch] = 1'b1;
        mx[wr_ch] = wr_x;
        my[wr_ch] = wr_y;
        mp[wr_ch] = wr_p;
        mop[wr_ch] = wr_op;
        mpend[wr_ch] = 1'b1;
      end
    end
  end
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        nvalid++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result: got ch=%0d x=%0h at cyc=%0d, required no out_valid", out_ch, out_x, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (e.due != cyc || out_ch != e.ch || out_x != e.x || out_y != e.y || out_p != e.p) begin
            errors++;
            $display("FAIL result: got cyc=%0d ch=%0d x=%0h y=%0h p=%0h, required cyc=%0d ch=%0d x=%0h y=%0h p=%0h",
                     cyc, out_ch, out_x, out_y, out_p, e.due, e.ch, e.x, e.y, e.p);
          end
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_result: ch=%0d due at cyc=%0d, none by cyc=%0d", sb[0].ch, sb[0].due, cyc);
        void'(sb.pop_front());
      end
      checks++;
      if (overrun !== movr) begin
        errors++;
        $display("FAIL overrun: got %b required %b at cyc=%0d", overrun, movr, cyc);
      end
    end
  end
  task automatic wr(input int ch, input logic [W-1:0] x, input logic [W-1:0] y,
                    input logic [PW-1:0] p, input logic [1:0] op);
    wr_en = 1'b1;
    wr_ch = CW'(ch);
    wr_x = x;
    wr_y = y;
    wr_p = p;
    wr_op = op;
    @(negedge clk);
  endtask
  task automatic idle(input int n);
    wr_en = 1'b0;
    repeat (n) @(negedge clk);
  endtask
  task automatic check_zero(input string name);
    checks++;
    if ({c_op, c_x, c_y, c_p, out_valid, out_ch, out_x, out_y, out_p, overrun} != '0) begin
      errors++;
      $display("FAIL %s: got c_x=%0h out_valid=%b out_x=%0h overrun=%b, required all zero",
               name, c_x, out_valid, out_x, overrun);
    end
  endtask
  task automatic check_eq(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, got, req);
    end
  endtask
  initial begin
    int v0, v1;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check_zero("reset_state");
    rst = 1'b0;
    @(negedge clk);
    v0 = nvalid;
    wr(2, 18'd10000, '0, '0, 2'd0);
    wr_en = 1'b0;
    check_eq("c_x_not_early", int'(c_x), 0);
    @(negedge clk);
    check_eq("c_x_issue", int'(c_x), 10000);
    check_eq("c_op_issue", int'(c_op), 0);
    idle(30);
    check_eq("single_pulse_count", nvalid - v0, 1);
    v0 = nvalid;
    wr(0, 18'd1, 18'd7, 19'd3, 2'd1);
    wr(0, 18'd2, 18'd7, 19'd3, 2'd1);
    idle(30);
    check_eq("same_cycle_results", nvalid - v0, 2);
    for (int i = 0; i < 400; i++) begin
      if (i == 30) begin
        #1 v0 = nvalid;
      end
      wr(i % N, W'($urandom), W'($urandom), PW'($urandom), 2'($urandom));
    end
    #1 v1 = nvalid;
    check_eq("full_load_continuous", v1 - v0, 370);
    idle(30);
    repeat (1500) begin
      if ($urandom_range(0, 9) < 7) wr($urandom_range(0, N - 1), W'($urandom), W'($urandom), PW'($urandom), 2'($urandom));
      else idle(1);
    end
    for (int i = 0; i < 40; i++) begin
      if (i == 20) wr(3, W'($urandom), W'($urandom), PW'($urandom), 2'($urandom));
      else wr(1, W'($urandom), W'($urandom), PW'($urandom), 2'($urandom));
    end
    idle(30);
    for (int i = 0; i < N; i++) wr(i, W'($urandom), W'($urandom), PW'($urandom), 2'($urandom));
    idle(2);
    #2 rst = 1'b1;
    #1 check_zero("reset_midstream");
    idle(2);
    rst = 1'b0;
    v0 = nvalid;
    idle(40);
    #1 check_eq("no_valid_after_reset", nvalid - v0, 0);
    idle(5);
    check_eq("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
